// File: rtl/fsk_tx_sequencer_if.sv
// Byte handshake into the FSK frame sequencer.
// The producer drives in_data/in_valid and the sequencer answers with in_ready.
interface fsk_tx_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fsk_tx_sequencer.sv
// Serialises accepted bytes into preamble/start/data/stop symbols for the FSK modulator.
// Bytes offered on the last stop cycle chain straight into a new start bit.
module fsk_tx_sequencer #(
  parameter int unsigned SYM_LEN = 64,
  parameter int unsigned PRE_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  fsk_tx_sequencer_if.slave   in_if,
  output logic                tx_bit,
  output logic                tx_active,
  output logic                sym_strobe,
  output logic [15:0]         bytes_sent
);

  localparam int unsigned CntW = (SYM_LEN > 2) ? $clog2(SYM_LEN) : 1;
  localparam int unsigned PreW = (PRE_LEN > 2) ? $clog2(PRE_LEN) : 1;
  localparam logic [CntW-1:0] SymLast = CntW'(SYM_LEN - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(PRE_LEN - 1);

  typedef enum logic [2:0] {StIdle, StPre, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [CntW-1:0] sym_cnt_q, sym_cnt_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     bytes_q, bytes_d;
  logic            tx_bit_q, tx_bit_d;
  logic            tx_active_q, tx_active_d;
  logic            strobe_q, strobe_d;
  logic            sym_end, in_ready, accept;

  always_comb begin
    sym_end  = (sym_cnt_q == SymLast);
    in_ready = !rst && ((state_q == StIdle) || ((state_q == StStop) && sym_end));
    accept   = in_if.in_valid && in_ready;
  end

  assign in_if.in_ready = in_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bytes_d   = bytes_q;
    sym_cnt_d = sym_end ? '0 : sym_cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        sym_cnt_d = '0;
        if (accept) begin
          shreg_d   = in_if.in_data;
          pre_cnt_d = '0;
          state_d   = (PRE_LEN > 0) ? StPre : StStart;
        end
      end
      StPre: begin
        if (sym_end) begin
          if (pre_cnt_q == PreLast) begin
            pre_cnt_d = '0;
            state_d   = StStart;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        if (sym_end) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (sym_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (sym_end) begin
          bytes_d = bytes_q + 16'd1;
          if (accept) begin
            shreg_d = in_if.in_data;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      StPre:   tx_bit_d = ~pre_cnt_d[0];
      StStart: tx_bit_d = 1'b0;
      StData:  tx_bit_d = shreg_d[0];
      default: tx_bit_d = 1'b1;
    endcase
    tx_active_d = (state_d != StIdle);
    strobe_d    = tx_active_d && (sym_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      sym_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bytes_q     <= '0;
      tx_bit_q    <= 1'b1;
      tx_active_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      sym_cnt_q   <= sym_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bytes_q     <= bytes_d;
      tx_bit_q    <= tx_bit_d;
      tx_active_q <= tx_active_d;
      strobe_q    <= strobe_d;
    end
  end

  assign tx_bit     = tx_bit_q;
  assign tx_active  = tx_active_q;
  assign sym_strobe = strobe_q;
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Scoreboard bench: expected symbols are queued at each accept and popped on every sym_strobe.
// Two instances: SYM_LEN=4 with a 2-symbol preamble, and SYM_LEN=4 with no preamble.
module tb_fsk_tx_sequencer;
  localparam int unsigned SymLen = 4;
  localparam int unsigned PreA   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsk_tx_sequencer_if bus_a ();
  fsk_tx_sequencer_if bus_z ();

  logic        a_tx_bit, a_tx_active, a_sym_strobe;
  logic [15:0] a_bytes;
  logic        z_tx_bit, z_tx_active, z_sym_strobe;
  logic [15:0] z_bytes;

  fsk_tx_sequencer #(.SYM_LEN(SymLen), .PRE_LEN(PreA)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus_a),
    .tx_bit     (a_tx_bit),
    .tx_active  (a_tx_active),
    .sym_strobe (a_sym_strobe),
    .bytes_sent (a_bytes)
  );

  fsk_tx_sequencer #(.SYM_LEN(SymLen), .PRE_LEN(0)) dut_z (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus_z),
    .tx_bit     (z_tx_bit),
    .tx_active  (z_tx_active),
    .sym_strobe (z_sym_strobe),
    .bytes_sent (z_bytes)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit qa[$];
  bit qz[$];
  int act_a = 0, strb_a = 0, act_z = 0, strb_z = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_tx_active) act_a++;
      if (a_sym_strobe) begin
        strb_a++;
        check_eq("a_sym_pending", 32'(qa.size() != 0), 1);
        if (qa.size() != 0) check_eq("a_sym", 32'(a_tx_bit), 32'(qa.pop_front()));
      end
      if (z_tx_active) act_z++;
      if (z_sym_strobe) begin
        strb_z++;
        check_eq("z_sym_pending", 32'(qz.size() != 0), 1);
        if (qz.size() != 0) check_eq("z_sym", 32'(z_tx_bit), 32'(qz.pop_front()));
      end
    end
  end

  // Offer byte b on instance sel (0=a, 1=z); returns after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] b, input bit with_pre, input bit hold,
                      output int acc_cyc);
    int  n;
    bit  rdy;
    bit  syms[$];
    @(posedge clk); #1;
    if (sel) begin bus_z.in_data = b; bus_z.in_valid = 1'b1; end
    else     begin bus_a.in_data = b; bus_a.in_valid = 1'b1; end
    n = 0;
    @(negedge clk);
    rdy = sel ? bus_z.in_ready : bus_a.in_ready;
    while (!rdy && n < 1000) begin
      @(negedge clk);
      rdy = sel ? bus_z.in_ready : bus_a.in_ready;
      n++;
    end
    acc_cyc = cyc;
    if (!rdy) begin
      check_eq("accept_timeout", 32'(rdy), 1);
    end else begin
      if (with_pre) for (int i = 0; i < int'(PreA); i++) syms.push_back(i % 2 == 0);
      syms.push_back(1'b0);
      for (int i = 0; i < 8; i++) syms.push_back(b[i]);
      syms.push_back(1'b1);
      foreach (syms[i]) begin
        if (sel) qz.push_back(syms[i]);
        else     qa.push_back(syms[i]);
      end
    end
    @(posedge clk); #1;
    if (!hold) begin
      if (sel) bus_z.in_valid = 1'b0;
      else     bus_a.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    while ((sel ? z_tx_active : a_tx_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", 32'(sel ? z_tx_active : a_tx_active), 0);
  endtask

  task automatic clear_counts();
    act_a = 0; strb_a = 0; act_z = 0; strb_z = 0;
  endtask

  initial begin
    int c1, c2;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_z.in_valid = 1'b0; bus_z.in_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus_a.in_ready), 0);
    check_eq("rst_tx_bit", 32'(a_tx_bit), 1);
    check_eq("rst_tx_active", 32'(a_tx_active), 0);
    check_eq("rst_strobe", 32'(a_sym_strobe), 0);
    check_eq("rst_bytes", 32'(a_bytes), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus_a.in_ready), 1);

    // Single byte with preamble
    clear_counts();
    send(1'b0, 8'hA5, 1'b1, 1'b0, c1);
    wait_idle(1'b0);
    check_eq("single_active", act_a, 48);
    check_eq("single_strobes", strb_a, 12);
    check_eq("single_tx_bit", 32'(a_tx_bit), 1);
    check_eq("single_bytes", 32'(a_bytes), 1);
    check_eq("single_q_empty", qa.size(), 0);

    // Chaining with in_valid held high
    clear_counts();
    send(1'b0, 8'hA5, 1'b1, 1'b1, c1);
    send(1'b0, 8'h3C, 1'b0, 1'b0, c2);
    check_eq("chain_accept_cycle", c2 - c1, 48);
    wait_idle(1'b0);
    check_eq("chain_active", act_a, 88);
    check_eq("chain_strobes", strb_a, 22);
    check_eq("chain_bytes", 32'(a_bytes), 3);
    check_eq("chain_q_empty", qa.size(), 0);

    // Gap: second byte after IDLE reissues the preamble
    clear_counts();
    send(1'b0, 8'hA5, 1'b1, 1'b0, c1);
    wait_idle(1'b0);
    repeat (2) @(posedge clk);
    send(1'b0, 8'h3C, 1'b1, 1'b0, c2);
    wait_idle(1'b0);
    check_eq("gap_active", act_a, 96);
    check_eq("gap_bytes", 32'(a_bytes), 5);
    check_eq("gap_q_empty", qa.size(), 0);

    // Handshake hold-off during DATA
    clear_counts();
    send(1'b0, 8'h5A, 1'b1, 1'b0, c1);
    repeat (20) @(posedge clk);
    #1 bus_a.in_valid = 1'b1; bus_a.in_data = 8'hFF;
    @(negedge clk);
    check_eq("holdoff_in_ready", 32'(bus_a.in_ready), 0);
    @(posedge clk); #1 bus_a.in_valid = 1'b0;
    wait_idle(1'b0);
    check_eq("holdoff_active", act_a, 48);
    check_eq("holdoff_bytes", 32'(a_bytes), 6);
    repeat (10) @(negedge clk);
    check_eq("holdoff_no_frame", 32'(a_tx_active), 0);
    check_eq("holdoff_q_empty", qa.size(), 0);

    // Reset mid-DATA
    send(1'b0, 8'h0F, 1'b1, 1'b0, c1);
    repeat (33) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_in_ready", 32'(bus_a.in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    qa.delete();
    @(negedge clk);
    check_eq("midrst_tx_bit", 32'(a_tx_bit), 1);
    check_eq("midrst_tx_active", 32'(a_tx_active), 0);
    check_eq("midrst_bytes", 32'(a_bytes), 0);
    check_eq("midrst_in_ready_after", 32'(bus_a.in_ready), 1);

    // Wrap of bytes_sent
    force dut_a.bytes_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut_a.bytes_q;
    @(negedge clk);
    check_eq("wrap_preload", 32'(a_bytes), 32'hFFFF);
    send(1'b0, 8'h81, 1'b1, 1'b0, c1);
    wait_idle(1'b0);
    check_eq("wrap_bytes", 32'(a_bytes), 0);
    check_eq("wrap_q_empty", qa.size(), 0);

    // PRE_LEN = 0
    clear_counts();
    send(1'b1, 8'hFF, 1'b0, 1'b0, c1);
    wait_idle(1'b1);
    check_eq("nopre_strobes", strb_z, 10);
    check_eq("nopre_active", act_z, 40);
    check_eq("nopre_bytes", 32'(z_bytes), 1);
    check_eq("nopre_q_empty", qz.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
